dcache_miss_ctrl: RTL
=====================

Name: dcache_miss_ctrl

Overview:
- Sequencing controller for the data-cache data store.
- On a datapath miss it writes back the dirty victim block to RAM, then fetches the requested block word by word and commits it to the store.
- On halt it walks every frame and writes back all dirty blocks, then asserts flushed.
- Sits between the datapath request lines, the data store (hit/dirty status, fill strobes) and the RAM/memory-arbiter port (ramREN/ramWEN/dwait).

Parameters:
- SETS, 8, number of sets; power of two.
- WAYS, 2, associativity; power of two.
- BLKWORDS, 2, 32-bit words per block; power of two, 2 or greater.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- halt  in  1  datapath halt request.
- dmemREN  in  1  datapath data read request.
- dmemWEN  in  1  datapath data write request.
- dmemaddr  in  32  datapath word address; bits [1:0] ignored.
- hit  in  1  data store: the current dmemaddr is resident.
- victim_dirty  in  1  data store: the LRU victim for dmemaddr's set is valid and dirty.
- victim_addr  in  32  data store: block base address of that victim.
- flush_dirty  in  1  data store: the frame at flush_idx is valid and dirty.
- flush_addr  in  32  data store: block base address of the frame at flush_idx.
- dwait  in  1  RAM busy; a transfer completes in the cycle dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM word address.
- word_sel  out  clog2(BLKWORDS)  word index for writeback data / fill target.
- fill_en  out  1  store writes the dload word into word_sel of the fill frame.
- fill_done  out  1  single-cycle pulse: mark frame valid, clean, new tag, update LRU.
- flush_idx  out  clog2(SETS*WAYS)  frame being examined during flush.
- flush_clr  out  1  single-cycle pulse: clear dirty bit of flush_idx.
- dhit  out  1  combinational: hit and state==IDLE and (dmemREN or dmemWEN).
- flushed  out  1  all dirty data written back; sticky until reset.

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE; word counter and flush index clear to 0.
  - All outputs are 0, including ramREN, ramWEN, fill_en, fill_done, flush_clr and flushed.
  - Reset mid-transfer abandons the transfer and strobes drop immediately.
- States: IDLE, WB, LOAD, COMMIT, FL_CHK, FL_WB, FL_CLR, HALTED.
- IDLE:
  - halt=1 → FL_CHK; flush_idx=0. Halt takes priority over a simultaneous miss.
  - Else, if (dmemREN|dmemWEN) and hit=0: go to WB if victim_dirty=1, else LOAD. word counter=0.
  - Simultaneous dmemREN and dmemWEN is treated as one request.
- WB:
  - ramWEN=1; ramaddr = victim_addr + 4*word.
  - On dwait=0: if word == BLKWORDS-1 → LOAD with word=0, else word+1.
  - victim_addr is captured on IDLE exit so that store changes cannot move it.
- LOAD:
  - ramREN=1; ramaddr = {dmemaddr[31:2+log2(BLKWORDS)], word, 2'b00}.
  - fill_en = ~dwait; word_sel = word.
  - On dwait=0 at the last word → COMMIT.
- COMMIT: fill_done=1 for one cycle → IDLE. The next cycle the store reports hit=1 and dhit asserts.
- FL_CHK: flush_dirty=1 → FL_WB with word=0; else advance.
- FL_WB:
  - ramWEN=1; ramaddr = flush_addr + 4*word.
  - Last word with dwait=0 → FL_CLR.
- FL_CLR: flush_clr=1 for one cycle, then advance.
- Advance: if flush_idx == SETS*WAYS-1 → HALTED, else flush_idx+1 → FL_CHK.
- HALTED: flushed=1; no RAM strobes; stays until reset.
- Strobe rules:
  - ramREN and ramWEN are never both 1.
  - Strobes stay steady (with a stable address) while dwait=1.
  - dwait may stay high indefinitely; the controller does not time out.
- Width rules:
  - The word counter is clog2(BLKWORDS) bits and wraps naturally.
  - Address adds are 32-bit modulo. Block base addresses are aligned, so there is no carry beyond the offset field.
- Request lines are not re-checked inside WB/LOAD. The datapath is stalled (dhit=0) and holds dmemaddr stable until dhit.

Decomposition:
- cpu_types_pkg holds:
  - dcache_state_t enum;
  - constants DSETS, DWAYS, DBLKWORDS;
  - derived widths DWORD_W and DFRAME_W;
  - word_t, which is reused for the address ports.
- One natural sub-module: dcache_xfer_seq. It is the word-counter/strobe engine shared by WB, LOAD and FL_WB. Inputs: start, is_read, base address, dwait. Outputs: ramaddr, strobe, word_sel, done.
- The top-level FSM selects the base address and direction.

Test Plan:
- Read miss, clean victim, BLKWORDS=2, dmemaddr=0x104, dwait low after 2 cycles → ramREN reads 0x100 then 0x104; fill_en word 0 then 1; fill_done pulse; dhit next cycle; ramWEN never asserts.
- Write miss, dirty victim at 0x200 → ramWEN to 0x200 and 0x204, then ramREN to the requested block; strobes never overlap.
- dwait held high 10 cycles mid-LOAD → ramaddr and ramREN stable; fill_en=0 throughout; fill_en=1 only in the dwait=0 cycle.
- Halt with dirty frames 0 and 5 (SETS*WAYS=16) → writebacks to their flush_addr only, a flush_clr pulse after each, flushed=1 after idx 15 and it stays high.
- halt and a miss together in IDLE → flush taken, no fill; RST asserted in the middle of WB → all outputs 0 asynchronously, IDLE on release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and sizing for the data-cache miss controller.
// Holds the cache geometry (sets, ways, words per block), the derived index widths,
// the 32-bit word type used for every address port, the controller state encoding
// and the RAM strobe pair produced by the transfer sequencer.
package cpu_types_pkg;

    // Cache geometry; all three must be powers of two, DBLKWORDS >= 2.
    localparam int unsigned DSETS     = 8;
    localparam int unsigned DWAYS     = 2;
    localparam int unsigned DBLKWORDS = 2;

    // Word index inside a block, and frame index across the whole store.
    localparam int unsigned DWORD_W  = $clog2(DBLKWORDS);
    localparam int unsigned DFRAME_W = $clog2(DSETS * DWAYS);

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StLoad,
        StCommit,
        StFlChk,
        StFlWb,
        StFlClr,
        StHalted
    } dcache_state_t;

    typedef struct packed {
        logic ren;
        logic wen;
    } ram_strobe_t;

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Bundle of the datapath request lines, data-store status/control and the RAM port
// around the miss controller.
// master: the controller (drives RAM strobes, fill/flush controls, dhit, flushed).
// slave : the surrounding datapath, data store and memory arbiter.
interface dcache_miss_ctrl_if;
    import cpu_types_pkg::*;

    // Datapath
    logic                halt;
    logic                dmemREN;
    logic                dmemWEN;
    word_t               dmemaddr;
    logic                dhit;
    logic                flushed;
    // Data store status
    logic                hit;
    logic                victim_dirty;
    word_t               victim_addr;
    logic                flush_dirty;
    word_t               flush_addr;
    // Data store control
    logic [DWORD_W-1:0]  word_sel;
    logic                fill_en;
    logic                fill_done;
    logic [DFRAME_W-1:0] flush_idx;
    logic                flush_clr;
    // RAM / arbiter
    logic                dwait;
    logic                ramREN;
    logic                ramWEN;
    word_t               ramaddr;

    modport master (
        input  halt, dmemREN, dmemWEN, dmemaddr, hit, victim_dirty, victim_addr,
               flush_dirty, flush_addr, dwait,
        output ramREN, ramWEN, ramaddr, word_sel, fill_en, fill_done, flush_idx,
               flush_clr, dhit, flushed
    );

    modport slave (
        output halt, dmemREN, dmemWEN, dmemaddr, hit, victim_dirty, victim_addr,
               flush_dirty, flush_addr, dwait,
        input  ramREN, ramWEN, ramaddr, word_sel, fill_en, fill_done, flush_idx,
               flush_clr, dhit, flushed
    );

endinterface

// File: rtl/dcache_xfer_seq.sv
// Block transfer engine shared by victim writeback, block fetch and flush writeback.
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   start     begin a block transfer at word 0 (overrides any transfer in progress)
//   is_read   direction for the transfer being started (1 = RAM read)
//   base      block base address, sampled every cycle while busy
//   dwait     RAM busy; a word completes in a cycle with dwait=0
//   ramaddr   base + 4*word while busy, else 0
//   strobe    ren/wen pair, at most one set, held while dwait=1
//   word_sel  current word index
//   done      last word completes this cycle
module dcache_xfer_seq
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               is_read,
    input  word_t              base,
    input  logic               dwait,
    output word_t              ramaddr,
    output ram_strobe_t        strobe,
    output logic [DWORD_W-1:0] word_sel,
    output logic               done
);

    logic               busy_q;
    logic               read_q;
    logic [DWORD_W-1:0] word_q;
    logic               last;

    assign last = (word_q == DWORD_W'(DBLKWORDS - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= 1'b0;
            read_q <= 1'b0;
            word_q <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            read_q <= is_read;
            word_q <= '0;
        end else if (busy_q && !dwait) begin
            // Counter wraps to 0 after the last word, ready for the next block.
            word_q <= word_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_comb begin
        strobe.ren = busy_q & read_q;
        strobe.wen = busy_q & ~read_q;
        ramaddr    = '0;
        if (busy_q) begin
            // Base is block aligned, so the offset never carries into the tag bits.
            ramaddr = base + {{(30 - DWORD_W){1'b0}}, word_q, 2'b00};
        end
    end

    assign word_sel = word_q;
    assign done     = busy_q & ~dwait & last;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer. On a miss it writes back a dirty victim, fetches the
// requested block word by word and commits it; on halt it walks every frame, writes
// back each dirty one and then reports flushed until reset.
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   bus       dcache_miss_ctrl_if.master: datapath requests, store status/control,
//             RAM strobes and address
module dcache_miss_ctrl
    import cpu_types_pkg::*;
(
    input logic                CLK,
    input logic                RST,
    dcache_miss_ctrl_if.master bus
);

    dcache_state_t       state_q, state_d;
    logic [DFRAME_W-1:0] flush_idx_q, flush_idx_d;
    word_t               victim_q, victim_d;

    logic               xfer_start;
    logic               xfer_read;
    logic               xfer_done;
    word_t              xfer_base;
    word_t              xfer_addr;
    ram_strobe_t        xfer_strobe;
    logic [DWORD_W-1:0] xfer_word;
    word_t              load_base;
    logic               req;
    logic               unused_addr_bits;

    assign req       = bus.dmemREN | bus.dmemWEN;
    assign load_base = {bus.dmemaddr[31:2+DWORD_W], {DWORD_W{1'b0}}, 2'b00};
    // Word offset and byte bits are replaced by the counter; kept only for lint.
    assign unused_addr_bits = ^bus.dmemaddr[DWORD_W+1:0];

    dcache_xfer_seq u_xfer (
        .CLK      (CLK),
        .RST      (RST),
        .start    (xfer_start),
        .is_read  (xfer_read),
        .base     (xfer_base),
        .dwait    (bus.dwait),
        .ramaddr  (xfer_addr),
        .strobe   (xfer_strobe),
        .word_sel (xfer_word),
        .done     (xfer_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            flush_idx_q <= '0;
            victim_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            victim_q    <= victim_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_idx_d   = flush_idx_q;
        victim_d      = victim_q;
        xfer_start    = 1'b0;
        xfer_read     = 1'b0;
        bus.fill_done = 1'b0;
        bus.flush_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.halt) begin
                    state_d     = StFlChk;
                    flush_idx_d = '0;
                end else if (req && !bus.hit) begin
                    xfer_start = 1'b1;
                    // Freeze the victim so later store updates cannot move the writeback.
                    victim_d   = bus.victim_addr;
                    if (bus.victim_dirty) begin
                        state_d = StWb;
                    end else begin
                        state_d   = StLoad;
                        xfer_read = 1'b1;
                    end
                end
            end
            StWb: begin
                if (xfer_done) begin
                    state_d    = StLoad;
                    xfer_start = 1'b1;
                    xfer_read  = 1'b1;
                end
            end
            StLoad: begin
                if (xfer_done) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                bus.fill_done = 1'b1;
                state_d       = StIdle;
            end
            StFlChk: begin
                if (bus.flush_dirty) begin
                    state_d    = StFlWb;
                    xfer_start = 1'b1;
                end else if (flush_idx_q == DFRAME_W'(DSETS * DWAYS - 1)) begin
                    state_d = StHalted;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
            StFlWb: begin
                if (xfer_done) begin
                    state_d = StFlClr;
                end
            end
            StFlClr: begin
                bus.flush_clr = 1'b1;
                if (flush_idx_q == DFRAME_W'(DSETS * DWAYS - 1)) begin
                    state_d = StHalted;
                end else begin
                    state_d     = StFlChk;
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            StWb:    xfer_base = victim_q;
            StLoad:  xfer_base = load_base;
            StFlWb:  xfer_base = bus.flush_addr;
            default: xfer_base = '0;
        endcase
    end

    assign bus.ramREN    = xfer_strobe.ren;
    assign bus.ramWEN    = xfer_strobe.wen;
    assign bus.ramaddr   = xfer_addr;
    assign bus.word_sel  = xfer_word;
    assign bus.fill_en   = (state_q == StLoad) & xfer_strobe.ren & ~bus.dwait;
    assign bus.flush_idx = flush_idx_q;
    assign bus.dhit      = bus.hit & (state_q == StIdle) & req;
    assign bus.flushed   = (state_q == StHalted);

endmodule
